// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package multicycle_pkg;

  // Opcodes the controller understands
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Controller sequencing states
  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ,
    JAL,
    TRAP
  } state_t;

  // Immediate extender selects
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Coarse ALU request handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU source muxes
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Per-state control word; enables that depend on live inputs are kept as qualifiers
  typedef struct packed {
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_always;
    logic       pc_on_ready;
    logic       pc_on_zero;
    logic       ir_on_ready;
    logic       mem_write_on_ready;
    logic       reg_write;
  } ctrl_t;

  // Moore control word for a given state; anything not set stays 0
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alu_src_a   = SRCA_PC;
        c.alu_src_b   = SRCB_FOUR;
        c.alu_op      = ALUOP_ADD;
        c.result_src  = RES_ALURESULT;
        c.pc_on_ready = 1'b1;
        c.ir_on_ready = 1'b1;
      end
      DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
      end
      MEMREAD: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.adr_src            = 1'b1;
        c.mem_write_on_ready = 1'b1;
      end
      EXECUTER: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_RD2;
        c.alu_op    = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      BEQ: begin
        c.alu_src_a  = SRCA_RD1;
        c.alu_src_b  = SRCB_RD2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.pc_on_zero = 1'b1;
      end
      JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALUOUT;
        c.pc_always  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Immediate format implied by the opcode
  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    logic [1:0] sel;
    case (op)
      OP_SW:   sel = IMM_S;
      OP_BEQ:  sel = IMM_B;
      OP_JAL:  sel = IMM_J;
      default: sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: turns the coarse ALU request plus instruction fields into an ALU operation.
module alu_decoder
  import multicycle_pkg::*;
#(
  parameter int F3_W = 3
) (
  input  logic [1:0]      alu_op,
  input  logic [F3_W-1:0] funct3,
  input  logic            funct7b5,
  input  logic            op5,
  output logic [2:0]      alu_control
);

  // Subtract on funct3 000 only for register-register ops with funct7[5] set
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I controller: sequences PC, memory, register file and ALU per instruction.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int OP_W = 7,
  parameter int F3_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic [F3_W-1:0] funct3,
  input  logic            funct7b5,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            adr_src,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_write,
  output logic [1:0]      result_src,
  output logic [1:0]      alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [2:0]      alu_control,
  output logic [1:0]      imm_src,
  output logic            illegal
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl_q, ctrl_d;

  // Next state, sticky illegal flag and the control word for the upcoming state
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTER;
          OP_IALU:      state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
    illegal_d = illegal_q | (state_d == TRAP);
    ctrl_d    = state_ctrl(state_d);
  end

  // State register with registered control word; reset lands in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      ctrl_q    <= state_ctrl(FETCH);
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Qualify enables with the handshake, branch flag and reset
  always_comb begin
    adr_src    = ctrl_q.adr_src;
    result_src = ctrl_q.result_src;
    alu_src_a  = ctrl_q.alu_src_a;
    alu_src_b  = ctrl_q.alu_src_b;
    pc_write   = rst_n & (ctrl_q.pc_always
                          | (ctrl_q.pc_on_ready & mem_ready)
                          | (ctrl_q.pc_on_zero & zero));
    ir_write   = rst_n & ctrl_q.ir_on_ready & mem_ready;
    mem_write  = rst_n & ctrl_q.mem_write_on_ready & mem_ready;
    reg_write  = rst_n & ctrl_q.reg_write;
    imm_src    = imm_src_for(op);
    illegal    = illegal_q;
  end

  alu_decoder #(
    .F3_W(F3_W)
  ) u_alu_decoder (
    .alu_op     (ctrl_q.alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alu_control(alu_control)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction micro-step model plus directed literal checks.
module tb_multicycle_control;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  multicycle_control #(.OP_W(7), .F3_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // One micro-step of an instruction. alu: 0 add, 1 sub, 2 funct-decoded.
  // pc: 0 never, 1 always, 2 when mem_ready, 3 when zero. hold: waits for mem_ready.
  typedef struct {
    int adr; int res; int a; int b; int alu; int pc;
    bit ir_m; bit mw_m; bit rw; bit hold; bit trap;
  } step_t;

  step_t prog[$];
  int    idx;
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    chk_en   = 1'b0;

  int s_pc, s_ir, s_mw, s_rw, s_res, s_alu, s_imm, s_ill;

  function automatic step_t mk(int adr, int res, int a, int b, int alu, int pc,
                               bit ir_m, bit mw_m, bit rw, bit hold, bit trap);
    step_t s;
    s.adr = adr; s.res = res; s.a = a; s.b = b; s.alu = alu; s.pc = pc;
    s.ir_m = ir_m; s.mw_m = mw_m; s.rw = rw; s.hold = hold; s.trap = trap;
    return s;
  endfunction

  function automatic step_t fetchStep();
    return mk(0, 2, 0, 2, 0, 2, 1, 0, 0, 1, 0);
  endfunction

  function automatic void startInstr();
    prog.delete();
    prog.push_back(fetchStep());
    prog.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    idx = 0;
  endfunction

  // Remaining micro-steps once the opcode is known
  function automatic void appendBody(logic [6:0] o);
    step_t aluwb;
    aluwb = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    case (o)
      T_LW: begin
        prog.push_back(mk(0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        prog.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      end
      T_SW: begin
        prog.push_back(mk(0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      end
      T_R: begin
        prog.push_back(mk(0, 0, 2, 0, 2, 0, 0, 0, 0, 0, 0));
        prog.push_back(aluwb);
      end
      T_I: begin
        prog.push_back(mk(0, 0, 2, 1, 2, 0, 0, 0, 0, 0, 0));
        prog.push_back(aluwb);
      end
      T_BEQ: prog.push_back(mk(0, 0, 2, 0, 1, 3, 0, 0, 0, 0, 0));
      T_JAL: begin
        prog.push_back(mk(0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0));
        prog.push_back(aluwb);
      end
      default: prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    endcase
  endfunction

  function automatic int expImm(logic [6:0] o);
    if (o == T_SW) return 1;
    if (o == T_BEQ) return 2;
    if (o == T_JAL) return 3;
    return 0;
  endfunction

  function automatic int expAlu(logic [2:0] f3, logic f7, bit is_r);
    if (f3 == 3'd0) return (is_r && f7) ? 1 : 0;
    if (f3 == 3'd2) return 5;
    if (f3 == 3'd6) return 3;
    if (f3 == 3'd7) return 2;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance on each rising edge
  always @(posedge clk) begin
    if (!rst_n) startInstr();
    else if (prog[idx].trap) begin
    end else if (prog[idx].hold && !mem_ready) begin
    end else begin
      if (idx == 1) appendBody(op);
      idx++;
      if (idx >= prog.size()) startInstr();
    end
  end

  task automatic checkModel();
    step_t s;
    int ealu, epc, eir, emw, erw, eill;
    s = rst_n ? prog[idx] : fetchStep();
    ealu = (s.alu == 2) ? expAlu(funct3, funct7b5, op == T_R) : s.alu;
    epc  = (s.pc == 1) || (s.pc == 2 && mem_ready) || (s.pc == 3 && zero);
    eir  = s.ir_m && mem_ready;
    emw  = s.mw_m && mem_ready;
    erw  = s.rw;
    eill = s.trap;
    if (!rst_n) begin
      epc = 0; eir = 0; emw = 0; erw = 0; eill = 0;
    end
    checkOutput("adr_src", adr_src, s.adr);
    checkOutput("result_src", result_src, s.res);
    checkOutput("alu_src_a", alu_src_a, s.a);
    checkOutput("alu_src_b", alu_src_b, s.b);
    checkOutput("alu_control", alu_control, ealu);
    checkOutput("imm_src", imm_src, expImm(op));
    checkOutput("pc_write", pc_write, epc);
    checkOutput("ir_write", ir_write, eir);
    checkOutput("mem_write", mem_write, emw);
    checkOutput("reg_write", reg_write, erw);
    checkOutput("illegal", illegal, eill);
  endtask

  // Continuous comparison against the model, mid low phase
  always @(negedge clk) begin
    #1;
    if (chk_en) checkModel();
  end

  // Drive one cycle's handshake inputs, sample outputs, move to the next cycle
  task automatic applyStimulus(input logic mr, input logic z);
    mem_ready = mr;
    zero      = z;
    #1;
    s_pc = pc_write; s_ir = ir_write; s_mw = mem_write; s_rw = reg_write;
    s_res = result_src; s_alu = alu_control; s_imm = imm_src; s_ill = illegal;
    @(negedge clk);
    #2;
  endtask

  // Run one instruction from FETCH with mem_ready held high
  task automatic runInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic z, output int len, output int rw_n, output int rw_res,
                          output int pc_n, output int mw_n, output int ex_alu, output int imm);
    op = o; funct3 = f3; funct7b5 = f7;
    len = 0; rw_n = 0; rw_res = -1; pc_n = 0; mw_n = 0; ex_alu = -1; imm = -1;
    do begin
      applyStimulus(1'b1, z);
      len++;
      if (s_rw != 0) begin rw_n++; rw_res = s_res; end
      if (s_pc != 0) pc_n++;
      if (s_mw != 0) mw_n++;
      if (len == 1) imm = s_imm;
      if (len == 3) ex_alu = s_alu;
    end while (ir_write !== 1'b1 && len < 12);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int len, rw_n, rw_res, pc_n, mw_n, ex_alu, imm, cnt;
    logic [6:0] ops[6];
    ops[0] = T_LW; ops[1] = T_SW; ops[2] = T_R; ops[3] = T_I; ops[4] = T_BEQ; ops[5] = T_JAL;

    rst_n = 1'b0; op = T_LW; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    startInstr();
    repeat (2) @(negedge clk);
    #2;
    checkOutput("reset_ir_write", ir_write, 0);
    checkOutput("reset_pc_write", pc_write, 0);
    checkOutput("reset_illegal", illegal, 0);
    checkOutput("reset_alu_src_b", alu_src_b, 2);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    $display("[TB] directed instruction lengths");
    runInstr(T_LW, 3'd2, 1'b0, 1'b0, len, rw_n, rw_res, pc_n, mw_n, ex_alu, imm);
    checkOutput("lw_len", len, 5);
    checkOutput("lw_reg_write_pulses", rw_n, 1);
    checkOutput("lw_result_src", rw_res, 1);
    checkOutput("lw_imm_src", imm, 0);
    runInstr(T_SW, 3'd2, 1'b0, 1'b0, len, rw_n, rw_res, pc_n, mw_n, ex_alu, imm);
    checkOutput("sw_len", len, 4);
    checkOutput("sw_mem_write_pulses", mw_n, 1);
    checkOutput("sw_imm_src", imm, 1);
    runInstr(T_R, 3'd0, 1'b1, 1'b0, len, rw_n, rw_res, pc_n, mw_n, ex_alu, imm);
    checkOutput("r_sub_len", len, 4);
    checkOutput("r_sub_alu", ex_alu, 1);
    checkOutput("r_sub_reg_write_pulses", rw_n, 1);
    runInstr(T_R, 3'd0, 1'b0, 1'b0, len, rw_n, rw_res, pc_n, mw_n, ex_alu, imm);
    checkOutput("r_add_alu", ex_alu, 0);
    runInstr(T_I, 3'd0, 1'b1, 1'b0, len, rw_n, rw_res, pc_n, mw_n, ex_alu, imm);
    checkOutput("addi_alu", ex_alu, 0);
    checkOutput("addi_len", len, 4);
    runInstr(T_I, 3'd2, 1'b0, 1'b0, len, rw_n, rw_res, pc_n, mw_n, ex_alu, imm);
    checkOutput("slti_alu", ex_alu, 5);
    runInstr(T_BEQ, 3'd0, 1'b0, 1'b1, len, rw_n, rw_res, pc_n, mw_n, ex_alu, imm);
    checkOutput("beq_taken_len", len, 3);
    checkOutput("beq_taken_pc_pulses", pc_n, 2);
    checkOutput("beq_imm_src", imm, 2);
    runInstr(T_BEQ, 3'd0, 1'b0, 1'b0, len, rw_n, rw_res, pc_n, mw_n, ex_alu, imm);
    checkOutput("beq_not_taken_pc_pulses", pc_n, 1);
    runInstr(T_JAL, 3'd0, 1'b0, 1'b0, len, rw_n, rw_res, pc_n, mw_n, ex_alu, imm);
    checkOutput("jal_len", len, 4);
    checkOutput("jal_pc_pulses", pc_n, 2);
    checkOutput("jal_imm_src", imm, 3);

    $display("[TB] fetch stall and store stall");
    op = T_R; funct3 = 3'd7;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("stall_fetch_ir_write", s_ir, 0);
      checkOutput("stall_fetch_pc_write", s_pc, 0);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("fetch_release_ir_write", s_ir, 1);
    checkOutput("fetch_release_pc_write", s_pc, 1);
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("after_stall_back_in_fetch", ir_write, 1);

    op = T_SW; cnt = 0;
    repeat (3) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0);
      cnt += s_mw;
    end
    applyStimulus(1'b1, 1'b0);
    cnt += s_mw;
    checkOutput("sw_stall_mem_write_pulses", cnt, 1);
    checkOutput("sw_stall_back_in_fetch", ir_write, 1);

    $display("[TB] reset in the middle of a store");
    op = T_SW;
    repeat (3) applyStimulus(1'b1, 1'b0);
    mem_ready = 1'b1;
    checkOutput("memwrite_before_reset", mem_write, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("memwrite_during_reset", mem_write, 0);
    checkOutput("ir_write_during_reset", ir_write, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_ir_write", ir_write, 1);
    checkOutput("post_reset_adr_src", adr_src, 0);
    checkOutput("post_reset_illegal", illegal, 0);
    @(negedge clk);
    #2;

    $display("[TB] unsupported opcode");
    op = T_BAD;
    repeat (2) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkOutput("trap_illegal", s_ill, 1);
      checkOutput("trap_enables", s_pc + s_ir + s_mw + s_rw, 0);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("trap_cleared_by_reset", illegal, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    $display("[TB] randomized instruction stream");
    for (int c = 0; c < 1500; c++) begin
      if (idx == 0) begin
        op       = ops[$urandom_range(0, 5)];
        funct3   = 3'($urandom_range(0, 7));
        funct7b5 = 1'($urandom_range(0, 1));
      end
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle RV32I control unit.
- Sequences the shared datapath (PC, instruction/data memory port, register file, ALU, immediate extender) over several clock cycles per instruction.
- Drives the extender's 2-bit immediate-type select, all write enables, the mux selects, and the ALU operation.
- Waits on a memory-ready handshake before any memory-dependent state advances.

Parameters:
- OP_W, 7, opcode field width
- F3_W, 3, funct3 field width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_write  out  1  data memory write strobe
- ir_write  out  1  instruction/OldPC register enable
- reg_write  out  1  register-file write enable
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = RD1
- alu_src_b  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- illegal  out  1  sticky unsupported-opcode flag

Behaviour:
- Clocking and reset
  - Single always_ff state register, async reset when rst_n = 0.
  - Reset state is FETCH, illegal = 0.
  - While rst_n = 0, all enables (pc_write, ir_write, mem_write, reg_write) are forced to 0. Other outputs take their FETCH values.
  - Reset mid-instruction abandons the instruction; no partial write is issued after rst_n rises.
- imm_src is combinational on op in every state:
  - lw (0000011) or I-ALU (0010011) -> 00
  - sw (0100011) -> 01
  - beq (1100011) -> 10
  - jal (1101111) -> 11
  - anything else -> 00
- Other outputs are Moore functions of state. The only exceptions are pc_write in BEQ and the ir_write/pc_write/mem_write gating by mem_ready. Any output not listed for a state is 0.
- States and outputs:
  - FETCH: adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu add, result_src = 10. ir_write = pc_write = mem_ready. Go to DECODE when mem_ready, otherwise hold.
  - DECODE: alu_src_a = 01, alu_src_b = 01, alu add (branch target). Next state by op:
    - lw or sw -> MEMADR
    - R-type (0110011) -> EXECUTER
    - I-ALU -> EXECUTEI
    - beq -> BEQ
    - jal -> JAL
    - else -> TRAP
  - MEMADR: alu_src_a = 10, alu_src_b = 01, alu add. Go to MEMREAD if op = lw, else MEMWRITE.
  - MEMREAD: adr_src = 1, result_src = 00. Go to MEMWB when mem_ready, else hold.
  - MEMWB: result_src = 01, reg_write = 1. Go to FETCH.
  - MEMWRITE: adr_src = 1, mem_write = mem_ready. Go to FETCH when mem_ready, else hold.
  - EXECUTER: alu_src_a = 10, alu_src_b = 00, alu per decoder. Go to ALUWB.
  - EXECUTEI: alu_src_a = 10, alu_src_b = 01, alu per decoder. Go to ALUWB.
  - ALUWB: result_src = 00, reg_write = 1. Go to FETCH.
  - BEQ: alu_src_a = 10, alu_src_b = 00, alu sub, result_src = 00, pc_write = zero. Go to FETCH.
  - JAL: alu_src_a = 01, alu_src_b = 10, alu add, result_src = 00, pc_write = 1. Go to ALUWB.
  - TRAP: illegal = 1 (registered, sticky), all enables 0. Leaves only on reset.
- ALU decode (alu_op: 00 add, 01 sub, 10 funct-decoded):
  - funct3 000 -> sub only when R-type and funct7b5 = 1, else add
  - funct3 010 -> slt
  - funct3 110 -> or
  - funct3 111 -> and
  - other funct3 -> add
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R/I 4, beq 3, jal 4.
- Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No enable toggles during a stall.

Decomposition:
- Shared package multicycle_pkg holds:
  - state_t enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
  - opcode localparams
  - imm_src, alu_control, result_src and src-mux encodings
- One sub-module, alu_decoder: combinational, inputs alu_op/funct3/funct7b5/op[5], output alu_control.

Test Plan:
- Reset: rst_n = 0 mid-MEMWRITE with mem_ready = 1 -> mem_write = 0 immediately; after release, state FETCH and illegal = 0.
- lw: op = 0000011, mem_ready = 1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles; imm_src = 00; reg_write = 1 only in cycle 5 with result_src = 01.
- R-type sub: op = 0110011, funct3 = 000, funct7b5 = 1 -> alu_control = 001 in EXECUTER; same with funct7b5 = 0 -> 000; reg_write pulses once in ALUWB.
- beq: op = 1100011, imm_src = 10. With zero = 1 in cycle 3 -> pc_write = 1. With zero = 0 -> pc_write = 0. Both cases return to FETCH.
- Stall: FETCH with mem_ready = 0 for 3 cycles, then 1 -> ir_write and pc_write = 0 for 3 cycles, then a single-cycle pulse. sw MEMWRITE stalled for 2 cycles -> exactly one mem_write pulse.
- Illegal: op = 1111111 -> DECODE goes to TRAP; illegal = 1 stays high and all enables stay 0 for 10+ cycles until rst_n is asserted.
